uart_mmio_responder: RTL and testbench

- MMIO-side UART peripheral; the responder at the far end of the mmio_bus UART window (CPU offsets 0x400/0x404).
- Accepts tx_wen/rx_ren/uart_addr/uart_din strobes from the memory controller and returns uart_dout plus status flags.
- Contains TX FIFO + serializer, RX synchronizer + 16x-oversampled deserializer + RX FIFO, and a shared baud tick generator.
- Drives the board tx pin and samples the rx pin.

---
 rtl/uart_pkg.sv | 48 ++++
 rtl/uart_mmio_responder_if.sv | 22 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_mmio_responder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_uart_mmio_responder.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants, status bit positions and FSM state types for the UART MMIO responder.
// The UART_PARITY_EN macro adds the parity states (8E1 framing); without it frames are 8N1.
package uart_pkg;

    localparam logic [2:0] UART_DATA_OFS   = 3'b000;
    localparam logic [2:0] UART_STATUS_OFS = 3'b100;

    localparam int ST_RX_PRESENT = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_PARITY_ERR = 3;
    localparam int ST_FRAMING    = 4;
    localparam int ST_TX_IDLE    = 5;

    localparam int OVS   = 16;
    localparam int OVS_W = $clog2(OVS);
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
    localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Baud divider for one oversample tick, never below 1.
    function automatic int baud_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OVS);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_mmio_responder_if.sv
// Memory-controller side of the UART window: strobes and write data in, read data and flags out.
interface uart_mmio_responder_if;

    logic       tx_wen;
    logic       rx_ren;
    logic [2:0] uart_addr;
    logic [7:0] uart_din;
    logic [7:0] uart_dout;
    logic       tx_full;
    logic       rx_data_present;

    modport master (
        output tx_wen, rx_ren, uart_addr, uart_din,
        input  uart_dout, tx_full, rx_data_present
    );

    modport slave (
        input  tx_wen, rx_ren, uart_addr, uart_din,
        output uart_dout, tx_full, rx_data_present
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; push and pop in the same cycle both proceed, even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// UART peripheral behind the MMIO window: TX FIFO + serializer, 16x oversampled RX + FIFO, status register.
// Define UART_PARITY_EN for 8E1 frames with a sticky parity error flag; default build is 8N1.
module uart_mmio_responder
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_mmio_responder_if.slave  bus,
    input  logic                  rx,
    output logic                  tx
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int BCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BCW-1:0] DIV_LAST = BCW'(DIV - 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    // ---------------- baud tick ----------------
    logic [BCW-1:0] baud_cnt;
    logic           tick;

    assign tick = (baud_cnt == DIV_LAST);

    // NOTE: every clocked process uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       baud_cnt <= '0;
        else if (tick) baud_cnt <= '0;
        else           baud_cnt <= baud_cnt + 1'b1;
    end

    // ---------------- bus decode ----------------
    logic data_wr, data_rd, status_rd;

    assign data_wr   = bus.tx_wen && (bus.uart_addr == UART_DATA_OFS);
    assign data_rd   = bus.rx_ren && (bus.uart_addr == UART_DATA_OFS);
    assign status_rd = bus.rx_ren && (bus.uart_addr == UART_STATUS_OFS);

    // ---------------- TX path ----------------
    logic          tx_fifo_full, tx_fifo_empty, tx_load, tx_bit, tx_bit_end;
    logic [7:0]    tx_fifo_dout, tx_shift;
    logic [CW-1:0] tx_count;
    logic [OVS_W-1:0] tx_tick_cnt;
    logic [2:0]    tx_bit_cnt;
    tx_state_t     tx_state, tx_state_nx;
`ifdef UART_PARITY_EN
    logic          tx_par;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr && !tx_fifo_full),
        .pop   (tx_load),
        .din   (bus.uart_din),
        .dout  (tx_fifo_dout),
        .full  (tx_fifo_full),
        .empty (tx_fifo_empty),
        .count (tx_count)
    );

    assign tx_bit_end = tick && (tx_tick_cnt == OVS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_nx;
    end

    always_comb begin
        tx_state_nx = tx_state;
        case (tx_state)
            TX_IDLE:   if (!tx_fifo_empty) tx_state_nx = TX_START;
            TX_START:  if (tx_bit_end) tx_state_nx = TX_DATA;
`ifdef UART_PARITY_EN
            TX_DATA:   if (tx_bit_end && tx_bit_cnt == 3'd7) tx_state_nx = TX_PARITY;
            TX_PARITY: if (tx_bit_end) tx_state_nx = TX_STOP;
`else
            TX_DATA:   if (tx_bit_end && tx_bit_cnt == 3'd7) tx_state_nx = TX_STOP;
`endif
            // A queued byte starts straight out of the stop bit, with no idle gap.
            TX_STOP:   if (tx_bit_end) tx_state_nx = tx_fifo_empty ? TX_IDLE : TX_START;
            default:   tx_state_nx = TX_IDLE;
        endcase
    end

    // NOTE: defaults ahead of the case keep this combinational block from inferring latches.
    always_comb begin
        tx_load = 1'b0;
        tx_bit  = 1'b1;
        case (tx_state)
            TX_IDLE:   tx_load = !tx_fifo_empty;
            TX_START:  tx_bit  = 1'b0;
            TX_DATA:   tx_bit  = tx_shift[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_bit  = tx_par;
`endif
            TX_STOP:   tx_load = tx_bit_end && !tx_fifo_empty;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx          <= 1'b1;
            tx_shift    <= '0;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
`ifdef UART_PARITY_EN
            tx_par      <= 1'b0;
`endif
        end else begin
            tx <= tx_bit;
            if (tx_load) begin
                tx_shift    <= tx_fifo_dout;
                tx_tick_cnt <= '0;
                tx_bit_cnt  <= '0;
`ifdef UART_PARITY_EN
                tx_par      <= ^tx_fifo_dout;
`endif
            end else if (tick) begin
                tx_tick_cnt <= tx_tick_cnt + 1'b1;
                if (tx_bit_end && tx_state == TX_DATA) begin
                    tx_shift   <= {1'b0, tx_shift[7:1]};
                    tx_bit_cnt <= tx_bit_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- RX path ----------------
    logic [1:0]    rx_sync;
    logic          rx_s, rx_mid, rx_sample, rx_push;
    logic          set_overrun, set_framing, set_parity;
    logic          rx_fifo_full, rx_fifo_empty;
    logic [7:0]    rx_fifo_dout, rx_shift;
    logic [CW-1:0] rx_count;
    logic [OVS_W-1:0] rx_tick_cnt;
    logic [2:0]    rx_bit_cnt;
    rx_state_t     rx_state, rx_state_nx;
    logic          rx_overrun, framing_err, parity_err;

    assign rx_s      = rx_sync[1];
    assign rx_mid    = tick && (rx_tick_cnt == OVS_MID);
    assign rx_sample = tick && (rx_tick_cnt == OVS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], rx};
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (data_rd),
        .din   (rx_shift),
        .dout  (rx_fifo_dout),
        .full  (rx_fifo_full),
        .empty (rx_fifo_empty),
        .count (rx_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_s) rx_state_nx = RX_START;
            RX_START:     if (rx_mid) rx_state_nx = rx_s ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
            RX_DATA:      if (rx_sample && rx_bit_cnt == 3'd7) rx_state_nx = RX_PARITY;
            RX_PARITY:    if (rx_sample) rx_state_nx = RX_STOP;
`else
            RX_DATA:      if (rx_sample && rx_bit_cnt == 3'd7) rx_state_nx = RX_STOP;
`endif
            RX_STOP:      if (rx_sample) rx_state_nx = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            // A held break must return high before a new start bit is accepted.
            RX_WAIT_HIGH: if (rx_s) rx_state_nx = RX_IDLE;
            default:      rx_state_nx = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_push     = 1'b0;
        set_overrun = 1'b0;
        set_framing = 1'b0;
        set_parity  = 1'b0;
        case (rx_state)
`ifdef UART_PARITY_EN
            RX_PARITY: set_parity = rx_sample && (rx_s != ^rx_shift);
`endif
            RX_STOP: begin
                if (rx_sample) begin
                    rx_push     = rx_s;
                    set_overrun = rx_s && rx_fifo_full && !data_rd;
                    set_framing = !rx_s;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
        end else if (rx_state == RX_IDLE) begin
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
        end else if (tick) begin
            // Restart the count at mid start bit so later samples land mid-bit.
            if (rx_state == RX_START && rx_mid) rx_tick_cnt <= '0;
            else                                rx_tick_cnt <= rx_tick_cnt + 1'b1;
            if (rx_state == RX_DATA && rx_sample) begin
                rx_shift   <= {rx_s, rx_shift[7:1]};
                rx_bit_cnt <= rx_bit_cnt + 1'b1;
            end
        end
    end

    // ---------------- sticky flags and read mux ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overrun  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            rx_overrun  <= set_overrun || (rx_overrun && !status_rd);
            framing_err <= set_framing || (framing_err && !status_rd);
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= set_parity || (parity_err && !status_rd);
    end
`else
    assign parity_err = set_parity;
`endif

    logic [7:0] status;

    always_comb begin
        status                = '0;
        status[ST_RX_PRESENT] = !rx_fifo_empty;
        status[ST_TX_FULL]    = tx_fifo_full;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_PARITY_ERR] = parity_err;
        status[ST_FRAMING]    = framing_err;
        status[ST_TX_IDLE]    = (tx_count == '0) && (tx_state == TX_IDLE);
    end

    always_comb begin
        bus.uart_dout = 8'h00;
        case (bus.uart_addr)
            UART_DATA_OFS:   bus.uart_dout = rx_fifo_empty ? 8'h00 : rx_fifo_dout;
            UART_STATUS_OFS: bus.uart_dout = status;
            default:         ;
        endcase
    end

    assign bus.tx_full         = tx_fifo_full;
    assign bus.rx_data_present = (rx_count != '0);

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Self-checking bench for uart_mmio_responder at 16 clk per bit; a line-level monitor decodes tx frames.
module tb_uart_mmio_responder;

    localparam int CLK_FREQ = 1843200;
    localparam int BAUD     = 115200;
    localparam int DEPTH    = 16;
    localparam int BIT_CLKS = 16;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [2:0] A_DATA = 3'b000;
    localparam logic [2:0] A_STAT = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_line = 1'b1;
    logic tx_line;

    uart_mmio_responder_if bus ();

    uart_mmio_responder #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .rx  (rx_line),
        .tx  (tx_line)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit slot k of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && FRAME_BITS == 11) return ^b;
        return 1'b1;
    endfunction

    // Line monitor: samples each tx frame mid-bit and records byte, parity slot and stop level.
    logic [7:0] tx_seen[$];
    logic       tx_seen_par[$];
    logic       tx_seen_stop[$];

    initial begin : tx_monitor
        logic [7:0] b;
        logic       p, s;
        forever begin
            @(negedge clk);
            if (!rst && tx_line === 1'b0) begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    b[i] = tx_line;
                end
                p = 1'b0;
                if (FRAME_BITS == 11) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    p = tx_line;
                end
                repeat (BIT_CLKS) @(negedge clk);
                s = tx_line;
                tx_seen.push_back(b);
                tx_seen_par.push_back(p);
                tx_seen_stop.push_back(s);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        bus.tx_wen    = 1'b1;
        bus.uart_addr = a;
        bus.uart_din  = d;
        step(1);
        bus.tx_wen    = 1'b0;
        bus.uart_addr = A_DATA;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        bus.rx_ren    = 1'b1;
        bus.uart_addr = a;
        @(negedge clk);
        d = bus.uart_dout;
        step(1);
        bus.rx_ren    = 1'b0;
        bus.uart_addr = A_DATA;
    endtask

    // Drives one rx frame; pres reports rx_data_present at the start of the stop bit.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                           output logic pres);
        rx_line = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            step(BIT_CLKS);
        end
        if (FRAME_BITS == 11) begin
            rx_line = (^b) ^ par_flip;
            step(BIT_CLKS);
        end
        pres    = bus.rx_data_present;
        rx_line = stop_bit;
        step(BIT_CLKS);
    endtask

    task automatic clear_monitor();
        tx_seen.delete();
        tx_seen_par.delete();
        tx_seen_stop.delete();
    endtask

    initial begin : stim
        logic [7:0] d;
        logic       pres;
        logic [7:0] bytes[$];
        logic [7:0] b1, b2;
        int         n, errs;

        bus.tx_wen    = 1'b0;
        bus.rx_ren    = 1'b0;
        bus.uart_addr = A_DATA;
        bus.uart_din  = 8'h00;
        step(3);

        // Reset state, observed while rst is still high.
        check("rst_tx", tx_line, 1);
        check("rst_tx_full", bus.tx_full, 0);
        check("rst_rx_present", bus.rx_data_present, 0);
        check("rst_dout_data", bus.uart_dout, 8'h00);
        bus.uart_addr = A_STAT;
        #1;
        check("rst_dout_status", bus.uart_dout, 8'h20);
        bus.uart_addr = A_DATA;
        rst = 1'b0;
        step(2);

        // 1: exact waveform of a 0x55 frame.
        clear_monitor();
        bus_write(A_DATA, 8'h55);
        n = 0;
        @(negedge clk);
        while (tx_line !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t1_start_seen", (n < 20), 1);
        errs = 0;
        for (int k = 0; k < FRAME_BITS * BIT_CLKS; k++) begin
            if (tx_line !== frame_bit(8'h55, k / BIT_CLKS)) errs++;
            @(negedge clk);
        end
        check("t1_wave_bad_cycles", errs, 0);
        check("t1_idle_after_frame", tx_line, 1);
        step(4);
        bus_read(A_STAT, d);
        check("t1_status", d, 8'h20);
        check("t1_monitor_byte", tx_seen.size() == 1 ? tx_seen[0] : 8'hxx, 8'h55);

        // 2: receive 0xA3, read it, flag drops after the pop.
        send_rx(8'hA3, 1'b1, 1'b0, pres);
        check("t2_present_before_stop", pres, 0);
        check("t2_present_after_frame", bus.rx_data_present, 1);
        bus_read(A_DATA, d);
        check("t2_data", d, 8'hA3);
        check("t2_present_after_pop", bus.rx_data_present, 0);

        // 3: 18 back-to-back writes; DEPTH queued plus one in the shifter are accepted.
        clear_monitor();
        bytes.delete();
        for (int i = 0; i < 18; i++) bytes.push_back(8'($urandom));
        for (int i = 0; i < 18; i++) begin
            bus.tx_wen    = 1'b1;
            bus.uart_addr = A_DATA;
            bus.uart_din  = bytes[i];
            step(1);
            if (i == DEPTH - 1) check("t3_not_full_after_16", bus.tx_full, 0);
            if (i == DEPTH)     check("t3_full_after_17", bus.tx_full, 1);
        end
        bus.tx_wen = 1'b0;
        step(19 * FRAME_BITS * BIT_CLKS);
        check("t3_frame_count", tx_seen.size(), DEPTH + 1);
        errs = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i >= tx_seen.size()) errs++;
            else if (tx_seen[i] !== bytes[i] || tx_seen_stop[i] !== 1'b1 ||
                     tx_seen_par[i] !== ((FRAME_BITS == 11) ? ^bytes[i] : 1'b0)) errs++;
        end
        check("t3_frame_content_bad", errs, 0);
        check("t3_tx_full_cleared", bus.tx_full, 0);
        bus_read(A_STAT, d);
        check("t3_status", d, 8'h20);

        // 4: 17 frames without reads: 16 stored, the 17th overruns.
        bytes.delete();
        for (int i = 0; i < 17; i++) bytes.push_back(8'($urandom));
        for (int i = 0; i < 17; i++) send_rx(bytes[i], 1'b1, 1'b0, pres);
        step(4);
        bus_read(A_STAT, d);
        check("t4_status_overrun", d, 8'h25);
        bus_read(A_STAT, d);
        check("t4_status_cleared", d, 8'h21);
        for (int i = 0; i < DEPTH; i++) begin
            bus_read(A_DATA, d);
            check("t4_data_order", d, bytes[i]);
        end
        bus_read(A_STAT, d);
        check("t4_status_drained", d, 8'h20);

        // 5: framing error followed by a 40-bit break, then a clean frame.
        send_rx(8'($urandom), 1'b0, 1'b0, pres);
        step(40 * BIT_CLKS);
        rx_line = 1'b1;
        step(2 * BIT_CLKS);
        bus_read(A_STAT, d);
        check("t5_status_framing", d, 8'h30);
        bus_read(A_STAT, d);
        check("t5_single_framing", d, 8'h20);
        send_rx(8'h3C, 1'b1, 1'b0, pres);
        step(2);
        bus_read(A_DATA, d);
        check("t5_data_after_break", d, 8'h3C);

        // 7: random full-duplex traffic against the queue model.
        clear_monitor();
        for (int r = 0; r < 4; r++) begin
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            bus_write(A_DATA, b1);
            send_rx(b2, 1'b1, 1'b0, pres);
            step(2 * BIT_CLKS);
            bus_read(A_DATA, d);
            check("t7_rx_byte", d, b2);
            check("t7_tx_byte", tx_seen.size() > 0 ? tx_seen.pop_front() : 8'hxx, b1);
        end
        bus_read(A_STAT, d);
        check("t7_status", d, 8'h20);

`ifdef UART_PARITY_EN
        // Parity: 0x07 has odd weight so the even-parity bit is 1; a flipped parity bit is flagged.
        clear_monitor();
        bus_write(A_DATA, 8'h07);
        step(FRAME_BITS * BIT_CLKS + 20);
        check("par_tx_bit", tx_seen_par.size() > 0 ? tx_seen_par[0] : 1'bx, 1);
        send_rx(8'h07, 1'b1, 1'b0, pres);
        step(2);
        bus_read(A_STAT, d);
        check("par_good_status", d, 8'h21);
        bus_read(A_DATA, d);
        send_rx(8'h5A, 1'b1, 1'b1, pres);
        step(2);
        bus_read(A_STAT, d);
        check("par_bad_status", d, 8'h29);
        bus_read(A_DATA, d);
        check("par_bad_byte_kept", d, 8'h5A);
`endif

        // 6: asynchronous reset in the middle of TX bit 3 of 0x07.
        bus_write(A_DATA, 8'h07);
        n = 0;
        @(negedge clk);
        while (tx_line !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_start_seen", (n < 20), 1);
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        check("t6_bit3_low", tx_line, 0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_tx_async_high", tx_line, 1);
        step(2);
        rst = 1'b0;
        step(2);
        bus_read(A_STAT, d);
        check("t6_status", d, 8'h20);
        n = 0;
        for (int k = 0; k < 2 * FRAME_BITS * BIT_CLKS; k++) begin
            @(negedge clk);
            if (tx_line !== 1'b1) n++;
        end
        check("t6_no_resume_low_cycles", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
